// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : imem_loader
//  Purpose  : Byte-stream instruction loader. Receives a length-prefixed frame
//             over a valid/ready link, assembles 16-bit big-endian words and
//             writes them to instruction memory from address 0. Holds the CPU
//             until the whole program is in memory.
//  Options  : IMEM_LOADER_CHKSUM_EN - adds a trailing XOR checksum byte; a
//             mismatch ends the load in the error state.
//  Revision : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int PROG_CTR_WID = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [7:0]              in_byte,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic                    imem_wr_en,
    output logic [PROG_CTR_WID-1:0] imem_wr_addr,
    output logic [15:0]             imem_wr_data,
    output logic                    cpu_hold,
    output logic                    load_done,
    output logic                    load_err
);

    // Memory depth in words; a length above this cannot fit and is rejected.
    localparam logic [31:0] c_DEPTH = 32'd1 << PROG_CTR_WID;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_LEN_HI  = 4'd1,
        ST_LEN_LO  = 4'd2,
        ST_DATA_HI = 4'd3,
        ST_DATA_LO = 4'd4,
        ST_WRITE   = 4'd5,
        ST_CHKSUM  = 4'd6,
        ST_DONE    = 4'd7,
        ST_ERR     = 4'd8
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    state_t                  w_end_state;
    logic [15:0]             r_len;
    logic [16:0]             r_words;
    logic [PROG_CTR_WID-1:0] r_addr;
    logic [7:0]              r_hi;
    logic [15:0]             r_wr_data;
    logic                    w_ready;
    logic                    w_xfer;
    logic [15:0]             w_len;
`ifdef IMEM_LOADER_CHKSUM_EN
    logic [7:0]              r_xor;
`endif

    assign w_xfer = in_valid && w_ready;
    // Full word count as it becomes known on the LEN_LO transfer.
    assign w_len  = {r_len[15:8], in_byte};

    // The last data word (or an empty frame) leads to the checksum byte
    // when that option is built in, otherwise straight to completion.
`ifdef IMEM_LOADER_CHKSUM_EN
    assign w_end_state = ST_CHKSUM;
`else
    assign w_end_state = ST_DONE;
`endif

    assign in_ready     = w_ready;
    assign imem_wr_addr = r_addr;
    assign imem_wr_data = r_wr_data;

    // State register plus the datapath registers that follow the FSM.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_len     <= 16'd0;
            r_words   <= 17'd0;
            r_addr    <= '0;
            r_hi      <= 8'd0;
            r_wr_data <= 16'd0;
`ifdef IMEM_LOADER_CHKSUM_EN
            r_xor     <= 8'd0;
`endif
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        r_len   <= 16'd0;
                        r_words <= 17'd0;
                        r_addr  <= '0;
`ifdef IMEM_LOADER_CHKSUM_EN
                        r_xor   <= 8'd0;
`endif
                    end
                end
                ST_LEN_HI: if (w_xfer) r_len[15:8] <= in_byte;
                ST_LEN_LO: if (w_xfer) r_len[7:0]  <= in_byte;
                ST_DATA_HI: begin
                    if (w_xfer) begin
                        r_hi  <= in_byte;
`ifdef IMEM_LOADER_CHKSUM_EN
                        r_xor <= r_xor ^ in_byte;
`endif
                    end
                end
                ST_DATA_LO: begin
                    if (w_xfer) begin
                        r_wr_data <= {r_hi, in_byte};
`ifdef IMEM_LOADER_CHKSUM_EN
                        r_xor     <= r_xor ^ in_byte;
`endif
                    end
                end
                // Address wraps naturally at full depth; the 17-bit word
                // count is what terminates the load.
                ST_WRITE: begin
                    r_addr  <= r_addr + 1'b1;
                    r_words <= r_words + 17'd1;
                end
                default: ;
            endcase
        end
    end

    // Next-state decode and state-derived outputs.
    always_comb begin
        w_next     = r_state;
        w_ready    = 1'b0;
        imem_wr_en = 1'b0;
        cpu_hold   = 1'b1;
        load_done  = 1'b0;
        load_err   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_next = ST_LEN_HI;
            end
            ST_LEN_HI: begin
                w_ready = 1'b1;
                if (w_xfer) w_next = ST_LEN_LO;
            end
            ST_LEN_LO: begin
                w_ready = 1'b1;
                if (w_xfer) begin
                    if (w_len == 16'd0)
                        w_next = w_end_state;
                    else if ({16'd0, w_len} > c_DEPTH)
                        w_next = ST_ERR;
                    else
                        w_next = ST_DATA_HI;
                end
            end
            ST_DATA_HI: begin
                w_ready = 1'b1;
                if (w_xfer) w_next = ST_DATA_LO;
            end
            ST_DATA_LO: begin
                w_ready = 1'b1;
                if (w_xfer) w_next = ST_WRITE;
            end
            ST_WRITE: begin
                imem_wr_en = 1'b1;
                if (r_words + 17'd1 == {1'b0, r_len})
                    w_next = w_end_state;
                else
                    w_next = ST_DATA_HI;
            end
`ifdef IMEM_LOADER_CHKSUM_EN
            ST_CHKSUM: begin
                w_ready = 1'b1;
                if (w_xfer) w_next = (in_byte == r_xor) ? ST_DONE : ST_ERR;
            end
`endif
            ST_DONE: begin
                cpu_hold  = 1'b0;
                load_done = 1'b1;
                if (start) w_next = ST_LEN_HI;
            end
            ST_ERR: begin
                load_err = 1'b1;
                if (start) w_next = ST_LEN_HI;
            end
            default: w_next = ST_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imem_loader
//  Purpose  : Scoreboard bench for imem_loader. Frames are modelled as byte
//             lists; expected memory writes are queued when a frame is issued
//             and a monitor pops them on every write strobe.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    localparam int W     = 10;
    localparam int DEPTH = 1 << W;

    typedef logic [7:0] bq_t[$];

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [7:0]   in_byte = 8'd0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         imem_wr_en;
    logic [W-1:0] imem_wr_addr;
    logic [15:0]  imem_wr_data;
    logic         cpu_hold;
    logic         load_done;
    logic         load_err;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_addr_q[$];
    int exp_data_q[$];

    imem_loader #(.PROG_CTR_WID(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .in_byte      (in_byte),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .imem_wr_en   (imem_wr_en),
        .imem_wr_addr (imem_wr_addr),
        .imem_wr_data (imem_wr_data),
        .cpu_hold     (cpu_hold),
        .load_done    (load_done),
        .load_err     (load_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every write strobe, checks invariants.
    always @(negedge clk) begin
        if (reset) begin
            check("done_err_exclusive", int'(load_done & load_err), 0);
            check("cpu_hold_vs_done", int'(cpu_hold), int'(!load_done));
            if (imem_wr_en) begin
                check("ready_low_in_write", int'(in_ready), 0);
                if (exp_addr_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_write: 0x%0h@0x%0h, none expected",
                             imem_wr_data, imem_wr_addr);
                end else begin
                    check("wr_addr", int'(imem_wr_addr), exp_addr_q.pop_front());
                    check("wr_data", int'(imem_wr_data), exp_data_q.pop_front());
                end
            end
        end
    end

    task automatic check_reset_vals();
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_wr_en", int'(imem_wr_en), 0);
        check("rst_wr_addr", int'(imem_wr_addr), 0);
        check("rst_wr_data", int'(imem_wr_data), 0);
        check("rst_cpu_hold", int'(cpu_hold), 1);
        check("rst_load_done", int'(load_done), 0);
        check("rst_load_err", int'(load_err), 0);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Offers one byte; optional random idle cycles before it and an optional
    // stray start pulse that the loader must ignore mid-frame.
    task automatic send_byte(input logic [7:0] b, input bit gaps, input bit poke);
        int t;
        if (gaps) begin
            for (int g = 0; g < 8 && $urandom_range(0, 1) == 1; g++) begin
                in_valid = 1'b0;
                in_byte  = 8'($urandom);
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b1;
        in_byte  = b;
        start    = poke;
        t = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t > 100) begin
                n_cmp++;
                n_bad++;
                $display("FAIL byte_accept_timeout: byte 0x%0h never accepted", b);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    function automatic bq_t build(input int n);
        bq_t q;
        q.push_back(8'(n >> 8));
        q.push_back(8'(n));
        if (n <= DEPTH)
            for (int i = 0; i < 2 * n; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    task automatic wait_end(input int exp_done, input int exp_err, input int exp_addr);
        int t;
        t = 0;
        while (!(load_done || load_err) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            n_cmp++;
            n_bad++;
            $display("FAIL end_timeout: neither load_done nor load_err within bound");
        end else begin
            check("load_done", int'(load_done), exp_done);
            check("load_err", int'(load_err), exp_err);
            check("cpu_hold_end", int'(cpu_hold), exp_done ? 0 : 1);
            check("final_addr", int'(imem_wr_addr), exp_addr);
            check("writes_outstanding", exp_addr_q.size(), 0);
        end
        @(posedge clk);
        #1;
    endtask

    // Reference model: derives writes and outcome from the frame bytes.
    task automatic run_frame(input bq_t fr, input bit gaps, input bit bad_chk);
        int         n;
        int         exp_err;
        int         exp_addr;
        logic [7:0] chk;
        n        = (int'(fr[0]) << 8) | int'(fr[1]);
        exp_err  = 0;
        exp_addr = 0;
        chk      = 8'h00;
        if (n > DEPTH) begin
            exp_err = 1;
        end else begin
            for (int i = 0; i < n; i++) begin
                exp_addr_q.push_back(i % DEPTH);
                exp_data_q.push_back((int'(fr[2 + 2 * i]) << 8) | int'(fr[3 + 2 * i]));
                chk = chk ^ fr[2 + 2 * i] ^ fr[3 + 2 * i];
            end
            exp_addr = n % DEPTH;
`ifdef IMEM_LOADER_CHKSUM_EN
            fr.push_back(bad_chk ? (chk ^ 8'h01) : chk);
            if (bad_chk) exp_err = 1;
`else
            if (bad_chk) $display("note: no checksum byte in this build");
`endif
        end
        do_start();
        for (int i = 0; i < fr.size(); i++)
            send_byte(fr[i], gaps, gaps && i > 0 && $urandom_range(0, 5) == 0);
        wait_end(exp_err ? 0 : 1, exp_err, exp_addr);
    endtask

    initial begin
        bq_t f1;
        bq_t fr;
        f1 = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals();
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Directed frames
        run_frame(f1, 1'b0, 1'b0);
        run_frame('{8'h00, 8'h00}, 1'b0, 1'b0);
        run_frame('{8'h04, 8'h01}, 1'b0, 1'b0);
        run_frame('{8'h00, 8'h01, 8'hBE, 8'hEF}, 1'b0, 1'b0);
        run_frame(f1, 1'b1, 1'b0);

        // Reset during DATA_LO of word 1: only word 0 reaches memory
        exp_addr_q.push_back(0);
        exp_data_q.push_back(16'h1234);
        do_start();
        for (int i = 0; i < 5; i++) send_byte(f1[i], 1'b0, 1'b0);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset_vals();
        check("reset_writes_outstanding", exp_addr_q.size(), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        run_frame(f1, 1'b0, 1'b0);

        // Checksum frames (good and corrupted trailer)
        run_frame('{8'h00, 8'h01, 8'h12, 8'h34}, 1'b0, 1'b0);
        run_frame('{8'h00, 8'h01, 8'h12, 8'h34}, 1'b1, 1'b1);

        // Randomized frames
        for (int k = 0; k < 8; k++) begin
            fr = build($urandom_range(1, 12));
            run_frame(fr, 1'b1, ($urandom_range(0, 3) == 0));
        end
        run_frame(build($urandom_range(DEPTH + 1, 65535)), 1'b1, 1'b0);
        run_frame(build(DEPTH + 1), 1'b0, 1'b0);
        run_frame(build(DEPTH), 1'b0, 1'b0);
        run_frame(build(1), 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
